vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for VGA-style displays. Two position counters walk
//   the visible area, front porch, sync pulse and back porch. The sync and
//   video-enable flags are registered. They are decoded from the next counter
//   values, so they line up with the counter values shown in the same cycle.
//
// Optional feature:
//   VGA_TIMING_FRAME_CNT_EN  -- when defined, frame_cnt counts completed frames
//                               modulo 256. When undefined, frame_cnt is tied
//                               to 0 and no register exists for it.
//
// Ports:
//   Clk            in   rising-edge clock
//   Reset          in   asynchronous, active-low reset
//   pix_en         in   pixel tick; the counters advance only while it is high
//   cntHorizontal  out  current pixel column, 0..H_TOTAL-1
//   cntVertical    out  current line, 0..V_TOTAL-1
//   hsync          out  horizontal sync; active level set by SYNC_POL
//   vsync          out  vertical sync; active level set by SYNC_POL
//   video_on       out  high inside the visible region
//   line_end       out  pulse on the pix_en cycle at the last column
//   frame_end      out  pulse on the pix_en cycle at the last column of the last line
//   frame_cnt      out  completed-frame counter (see the optional feature above)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 29,
  parameter int CNT_W     = 10,
  parameter int SYNC_POL  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] cntHorizontal,
  output logic [CNT_W-1:0] cntVertical,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_MAX        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_LIM    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LIM    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_IDLE = (SYNC_POL != 0) ? 1'b0 : 1'b1;

  logic [CNT_W-1:0] hCnt_r;
  logic [CNT_W-1:0] vCnt_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             videoOn_r;

  logic             hAtMax_s;
  logic             vAtMax_s;
  logic [CNT_W-1:0] hNext_s;
  logic [CNT_W-1:0] vNext_s;
  logic             hSyncNext_s;
  logic             vSyncNext_s;
  logic             videoNext_s;

  // Next-position arithmetic plus flag decode of that next position.
  always_comb begin
    hAtMax_s = (hCnt_r == H_MAX);
    vAtMax_s = (vCnt_r == V_MAX);
    hNext_s  = hCnt_r;
    vNext_s  = vCnt_r;
    if (pix_en) begin
      if (hAtMax_s) begin
        hNext_s = CNT_ZERO;
        if (vAtMax_s) begin
          vNext_s = CNT_ZERO;
        end else begin
          vNext_s = vCnt_r + CNT_ONE;
        end
      end else begin
        hNext_s = hCnt_r + CNT_ONE;
        vNext_s = vCnt_r;
      end
    end else begin
      hNext_s = hCnt_r;
      vNext_s = vCnt_r;
    end
    // The flags are decoded from the next position. Once registered, they
    // line up with the counters in the same cycle, with no lag.
    hSyncNext_s = ((hNext_s >= H_SYNC_FIRST) && (hNext_s <= H_SYNC_LAST)) ? SYNC_ACT : SYNC_IDLE;
    vSyncNext_s = ((vNext_s >= V_SYNC_FIRST) && (vNext_s <= V_SYNC_LAST)) ? SYNC_ACT : SYNC_IDLE;
    videoNext_s = (hNext_s < H_VIS_LIM) && (vNext_s < V_VIS_LIM);
  end

  // Position counters and registered timing flags.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hCnt_r    <= CNT_ZERO;
      vCnt_r    <= CNT_ZERO;
      hsync_r   <= SYNC_IDLE;
      vsync_r   <= SYNC_IDLE;
      videoOn_r <= 1'b1;
    end else begin
      hCnt_r    <= hNext_s;
      vCnt_r    <= vNext_s;
      hsync_r   <= hSyncNext_s;
      vsync_r   <= vSyncNext_s;
      videoOn_r <= videoNext_s;
    end
  end

  assign cntHorizontal = hCnt_r;
  assign cntVertical   = vCnt_r;
  assign hsync         = hsync_r;
  assign vsync         = vsync_r;
  assign video_on      = videoOn_r;

  // Event strobes decode the current position. They are gated by pix_en so
  // that a stalled pixel tick never repeats an event.
  assign line_end  = pix_en & hAtMax_s;
  assign frame_end = line_end & vAtMax_s;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frameCnt_r;

  // Completed-frame counter; it wraps naturally at 256.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frameCnt_r <= 8'd0;
    end else if (frame_end) begin
      frameCnt_r <= frameCnt_r + 8'd1;
    end else begin
      frameCnt_r <= frameCnt_r;
    end
  end

  assign frame_cnt = frameCnt_r;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboard bench with two instances:
//     - dutDef uses the default 640x480 timing, for the horizontal boundaries
//       and line wrap.
//     - dutSm uses a tiny timing with active-high syncs, for full frame wraps
//       and frame_end / frame_cnt.
//   The stimulus drives one cycle at a time and pushes that cycle's expected
//   outputs, computed from the number of pixel ticks since reset and from
//   hand-computed window limits. The monitor pops one entry on every falling
//   clock edge and compares it against both instances.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Small timing: H 8+2+3+2 = 15 (hsync at columns 10..12).
  //               V 4+1+2+1 = 8  (vsync at lines 5..6).
  //               One frame = 120 ticks.
  typedef struct packed {
    logic [9:0] dH;
    logic [9:0] dV;
    logic       dHs;
    logic       dVs;
    logic       dVid;
    logic       dLe;
    logic       dFe;
    logic [5:0] sH;
    logic [5:0] sV;
    logic       sHs;
    logic       sVs;
    logic       sVid;
    logic       sLe;
    logic       sFe;
    logic [7:0] sFc;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       pixEn;

  logic [9:0] dH, dV;
  logic       dHs, dVs, dVid, dLe, dFe;
  logic [7:0] dFc;
  logic [5:0] sH, sV;
  logic       sHs, sVs, sVid, sLe, sFe;
  logic [7:0] sFc;

  exp_t expQ[$];
  int   tick;
  int   checks;
  int   errors;
  int   cycleNo;

  vga_timing_gen dutDef (
    .Clk(Clk), .Reset(Reset), .pix_en(pixEn),
    .cntHorizontal(dH), .cntVertical(dV),
    .hsync(dHs), .vsync(dVs), .video_on(dVid),
    .line_end(dLe), .frame_end(dFe), .frame_cnt(dFc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CNT_W(6), .SYNC_POL(1)
  ) dutSm (
    .Clk(Clk), .Reset(Reset), .pix_en(pixEn),
    .cntHorizontal(sH), .cntVertical(sV),
    .hsync(sHs), .vsync(sVs), .video_on(sVid),
    .line_end(sLe), .frame_end(sFe), .frame_cnt(sFc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected outputs after t pixel ticks since reset, with pix_en = pe.
  function automatic exp_t makeExp(input int t, input logic pe);
    exp_t e;
    int   dh, dv, sh, sv;
    dh = t % 800;
    dv = (t / 800) % 521;
    sh = t % 15;
    sv = (t / 15) % 8;
    e.dH   = 10'(dh);
    e.dV   = 10'(dv);
    e.dHs  = !(dh >= 656 && dh <= 751);
    e.dVs  = !(dv >= 490 && dv <= 491);
    e.dVid = (dh < 640) && (dv < 480);
    e.dLe  = pe && (dh == 799);
    e.dFe  = pe && (dh == 799) && (dv == 520);
    e.sH   = 6'(sh);
    e.sV   = 6'(sv);
    e.sHs  = (sh >= 10) && (sh <= 12);
    e.sVs  = (sv >= 5) && (sv <= 6);
    e.sVid = (sh < 8) && (sv < 4);
    e.sLe  = pe && (sh == 14);
    e.sFe  = pe && (sh == 14) && (sv == 7);
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.sFc  = 8'((t / 120) % 256);
`else
    e.sFc  = 8'd0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycleNo, act, expv);
    end
  endtask

  // Drive one cycle, push its expectation, and then let the clock edge pass.
  task automatic cycle(input logic pe);
    pixEn = pe;
    expQ.push_back(makeExp(tick, pe));
    @(posedge Clk);
    #1;
    if (pe && Reset) tick++;
  endtask

  // Scoreboard monitor: compare one expectation per falling edge.
  always @(negedge Clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      cycleNo++;
      chk("def_h",        int'(dH),   int'(e.dH));
      chk("def_v",        int'(dV),   int'(e.dV));
      chk("def_hsync",    int'(dHs),  int'(e.dHs));
      chk("def_vsync",    int'(dVs),  int'(e.dVs));
      chk("def_video_on", int'(dVid), int'(e.dVid));
      chk("def_line_end", int'(dLe),  int'(e.dLe));
      chk("def_frame_end", int'(dFe), int'(e.dFe));
      chk("sm_h",         int'(sH),   int'(e.sH));
      chk("sm_v",         int'(sV),   int'(e.sV));
      chk("sm_hsync",     int'(sHs),  int'(e.sHs));
      chk("sm_vsync",     int'(sVs),  int'(e.sVs));
      chk("sm_video_on",  int'(sVid), int'(e.sVid));
      chk("sm_line_end",  int'(sLe),  int'(e.sLe));
      chk("sm_frame_end", int'(sFe),  int'(e.sFe));
      chk("sm_frame_cnt", int'(sFc),  int'(e.sFc));
      chk("def_frame_cnt", int'(dFc), 0);
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    tick    = 0;
    cycleNo = 0;
    Reset   = 1'b0;
    pixEn   = 1'b0;
    @(posedge Clk);
    #1;

    // Hold reset for a few cycles, then release it with the pixel tick idle.
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0);

    // Run the pixel tick continuously through two default lines. The small
    // instance wraps many frames in the same time.
    for (int i = 0; i < 1605; i++) cycle(1'b1);

    // Toggle the pixel tick on alternate cycles.
    for (int i = 0; i < 40; i++) cycle(i[0] ? 1'b0 : 1'b1);

    // Run until the small instance is mid-frame at line 3, column 7.
    while ((tick % 120) != 52) cycle(1'b1);

    // Assert reset between edges. The counters must clear before the next
    // rising edge, which the monitor checks on this cycle's falling edge.
    pixEn = 1'b1;
    Reset = 1'b0;
    tick  = 0;
    expQ.push_back(makeExp(tick, 1'b1));
    @(posedge Clk);
    #1;
    cycle(1'b1);
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1);
    pixEn = 1'b0;

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge Clk);
    if (expQ.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending entries, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
